// File: rtl/stk_pipe_lk_sched_if.sv
// Request, issue and completion signals between the context requesters, the LK-stage scheduler
// and the pipeline tail.
interface stk_pipe_lk_sched_if #(
    parameter int unsigned N_CTXT = 4,
    parameter int unsigned PTR_W  = 8
);
    localparam int unsigned CTXT_W = $clog2(N_CTXT);

    logic [N_CTXT-1:0]       i_req_vld;
    logic [N_CTXT*PTR_W-1:0] i_req_ptr;
    logic [N_CTXT-1:0]       o_req_ack;
    logic                    o_lk_vld_r;
    logic [PTR_W-1:0]        o_lk_ptr_r;
    logic [CTXT_W-1:0]       o_lk_ctxt_r;
    logic                    i_cpl_vld;
    logic [CTXT_W-1:0]       i_cpl_ctxt;
    logic [N_CTXT-1:0]       o_busy_r;
    logic [3:0]              o_credits_r;
    logic                    o_err_r;

    modport master (
        output i_req_vld, i_req_ptr, i_cpl_vld, i_cpl_ctxt,
        input  o_req_ack, o_lk_vld_r, o_lk_ptr_r, o_lk_ctxt_r, o_busy_r, o_credits_r, o_err_r
    );

    modport slave (
        input  i_req_vld, i_req_ptr, i_cpl_vld, i_cpl_ctxt,
        output o_req_ack, o_lk_vld_r, o_lk_ptr_r, o_lk_ctxt_r, o_busy_r, o_credits_r, o_err_r
    );
endinterface

// File: rtl/stk_pipe_lk_sched.sv
// Round-robin, credit-limited scheduler issuing one op per context into the stack pipeline LK
// stage; completions from the pipeline tail free the context and return its credit.
module stk_pipe_lk_sched #(
    parameter int unsigned N_CTXT  = 4,
    parameter int unsigned PTR_W   = 8,
    parameter int unsigned CREDITS = 4
) (
    input logic               clk,
    input logic               arst_n,
    stk_pipe_lk_sched_if.slave bus
);
    localparam int unsigned CTXT_W = $clog2(N_CTXT);

    logic [N_CTXT-1:0] busy_q, busy_d;
    logic [3:0]        credits_q, credits_d;
    logic [CTXT_W-1:0] rr_q, rr_d;
    logic              lk_vld_q;
    logic [PTR_W-1:0]  lk_ptr_q;
    logic [CTXT_W-1:0] lk_ctxt_q;
    logic              err_q, err_d;

    logic [N_CTXT-1:0] elig;
    logic [N_CTXT-1:0] ack;
    logic [CTXT_W-1:0] grant_idx;
    logic              grant_found;
    logic              issue;
    logic              cpl_ok;
    int unsigned       scan_idx;

    // Busy is the registered copy, so a context completing this cycle cannot be re-granted yet.
    assign elig = bus.i_req_vld & ~busy_q;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int unsigned i = 0; i < N_CTXT; i++) begin
            scan_idx = 32'(rr_q) + i;
            if (scan_idx >= N_CTXT) begin
                scan_idx = scan_idx - N_CTXT;
            end
            if (!grant_found && elig[scan_idx[CTXT_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[CTXT_W-1:0];
            end
        end
    end

    assign issue  = arst_n & grant_found & (credits_q != 4'd0);
    assign cpl_ok = bus.i_cpl_vld & busy_q[bus.i_cpl_ctxt];

    always_comb begin
        ack = '0;
        if (issue) begin
            ack[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (cpl_ok) begin
            busy_d[bus.i_cpl_ctxt] = 1'b0;
        end
        if (issue) begin
            busy_d[grant_idx] = 1'b1;
        end

        credits_d = credits_q;
        unique case ({issue, cpl_ok})
            2'b10:   credits_d = credits_q - 4'd1;
            2'b01:   credits_d = credits_q + 4'd1;
            default: credits_d = credits_q;
        endcase

        rr_d = rr_q;
        if (issue) begin
            rr_d = (grant_idx == CTXT_W'(N_CTXT - 1)) ? '0 : grant_idx + 1'b1;
        end

        err_d = err_q | (bus.i_cpl_vld & ~cpl_ok);
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            busy_q    <= '0;
            credits_q <= 4'(CREDITS);
            rr_q      <= '0;
            lk_vld_q  <= 1'b0;
            lk_ptr_q  <= '0;
            lk_ctxt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            credits_q <= credits_d;
            rr_q      <= rr_d;
            lk_vld_q  <= issue;
            err_q     <= err_d;
            if (issue) begin
                lk_ptr_q  <= bus.i_req_ptr[grant_idx*PTR_W +: PTR_W];
                lk_ctxt_q <= grant_idx;
            end
        end
    end

    assign bus.o_req_ack   = ack;
    assign bus.o_lk_vld_r  = lk_vld_q;
    assign bus.o_lk_ptr_r  = lk_ptr_q;
    assign bus.o_lk_ctxt_r = lk_ctxt_q;
    assign bus.o_busy_r    = busy_q;
    assign bus.o_credits_r = credits_q;
    assign bus.o_err_r     = err_q;
endmodule

// File: tb/tb_stk_pipe_lk_sched.sv
// Bench for stk_pipe_lk_sched: directed scenarios with literal expectations, then random
// requests/completions/resets checked every cycle against a context-level reference model.
module tb_stk_pipe_lk_sched;
    localparam int unsigned N  = 4;
    localparam int unsigned PW = 8;
    localparam int unsigned CR = 4;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    stk_pipe_lk_sched_if #(.N_CTXT(N), .PTR_W(PW)) bus ();

    stk_pipe_lk_sched #(.N_CTXT(N), .PTR_W(PW), .CREDITS(CR)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference state: which contexts hold an op, last issue, error flag, rr start point.
    logic [N-1:0]  m_busy    = '0;
    int            m_rr      = 0;
    bit            m_err     = 1'b0;
    bit            m_lk_vld  = 1'b0;
    logic [PW-1:0] m_lk_ptr  = '0;
    int            m_lk_ctxt = 0;
    logic [N-1:0]  last_ack  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Credits in hand are whatever the in-flight set does not consume.
    function automatic int model_credits();
        return int'(CR) - $countones(m_busy);
    endfunction

    function automatic int model_pick();
        if (!arst_n || model_credits() == 0) return -1;
        for (int i = 0; i < int'(N); i++) begin
            int k;
            k = (m_rr + i) % int'(N);
            if (bus.i_req_vld[k] && !m_busy[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ack();
        int g;
        logic [N-1:0] a;
        g = model_pick();
        a = '0;
        if (g >= 0) a[g] = 1'b1;
        return a;
    endfunction

    always @(posedge clk) begin
        int g;
        if (!arst_n) begin
            m_busy = '0; m_rr = 0; m_err = 1'b0; m_lk_vld = 1'b0;
            m_lk_ptr = '0; m_lk_ctxt = 0; last_ack = '0;
        end else begin
            g = model_pick();
            last_ack = model_ack();
            if (bus.i_cpl_vld) begin
                if (m_busy[bus.i_cpl_ctxt]) m_busy[bus.i_cpl_ctxt] = 1'b0;
                else m_err = 1'b1;
            end
            if (g >= 0) begin
                m_busy[g] = 1'b1;
                m_lk_vld  = 1'b1;
                m_lk_ptr  = bus.i_req_ptr[g*PW +: PW];
                m_lk_ctxt = g;
                m_rr      = (g + 1) % int'(N);
            end else begin
                m_lk_vld = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack",     32'(bus.o_req_ack),   32'(model_ack()));
            check("lk_vld",  32'(bus.o_lk_vld_r),  32'(m_lk_vld));
            check("lk_ptr",  32'(bus.o_lk_ptr_r),  32'(m_lk_ptr));
            check("lk_ctxt", 32'(bus.o_lk_ctxt_r), 32'(m_lk_ctxt));
            check("busy",    32'(bus.o_busy_r),    32'(m_busy));
            check("credits", 32'(bus.o_credits_r), 32'(model_credits()));
            check("err",     32'(bus.o_err_r),     32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpl(input bit vld, input int c);
        bus.i_cpl_vld  = vld;
        bus.i_cpl_ctxt = 2'(c);
    endtask

    initial begin
        logic [31:0] e;
        arst_n = 1'b0;
        bus.i_req_vld = '0;
        bus.i_req_ptr = '0;
        cpl(1'b0, 0);
        step();
        chk_en = 1'b1;
        step();

        // All four request after reset: granted 0,1,2,3 in turn until credits run out.
        arst_n = 1'b1;
        bus.i_req_vld = 4'hF;
        bus.i_req_ptr = 32'h44332211;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = (i < 4) ? (32'd1 << i) : 32'd0;
            check("A_ack", 32'(bus.o_req_ack), e);
            e = (i < 4) ? 32'(4 - i) : 32'd0;
            check("A_credits", 32'(bus.o_credits_r), e);
            if (i == 1) check("A_lk_ptr", 32'(bus.o_lk_ptr_r), 32'h11);
            step();
        end

        // Reset with ops in flight, then a lone request from ctxt 2.
        arst_n = 1'b0;
        bus.i_req_vld = '0;
        @(negedge clk);
        check("B_ack_in_reset", 32'(bus.o_req_ack), 32'd0);
        step();
        arst_n = 1'b1;
        bus.i_req_vld = 4'b0100;
        bus.i_req_ptr = 32'h00A50000;
        @(negedge clk);
        check("B_busy_rst", 32'(bus.o_busy_r), 32'd0);
        check("B_credits_rst", 32'(bus.o_credits_r), 32'd4);
        check("B_lk_vld_rst", 32'(bus.o_lk_vld_r), 32'd0);
        check("B_ack2", 32'(bus.o_req_ack), 32'b0100);
        step();
        bus.i_req_vld = '0;
        @(negedge clk);
        check("B_lk_vld", 32'(bus.o_lk_vld_r), 32'd1);
        check("B_lk_ptr", 32'(bus.o_lk_ptr_r), 32'hA5);
        check("B_lk_ctxt", 32'(bus.o_lk_ctxt_r), 32'd2);
        check("B_busy", 32'(bus.o_busy_r), 32'b0100);

        // Fill remaining credits; rr now starts at ctxt 3.
        step();
        bus.i_req_vld = 4'b1011;
        @(negedge clk);
        check("C_ack3", 32'(bus.o_req_ack), 32'b1000);
        step();
        bus.i_req_vld = 4'b0011;
        @(negedge clk);
        check("C_ack0", 32'(bus.o_req_ack), 32'b0001);
        step();
        bus.i_req_vld = 4'b0010;
        @(negedge clk);
        check("C_ack1", 32'(bus.o_req_ack), 32'b0010);
        step();
        bus.i_req_vld = '0;
        @(negedge clk);
        check("C_credits0", 32'(bus.o_credits_r), 32'd0);
        check("C_busy_all", 32'(bus.o_busy_r), 32'hF);
        // Completion and request from ctxt 3 in the same cycle: no grant until the next one.
        step();
        bus.i_req_vld = 4'b1000;
        cpl(1'b1, 3);
        @(negedge clk);
        check("C_same_cycle_ack", 32'(bus.o_req_ack), 32'd0);
        step();
        cpl(1'b0, 0);
        @(negedge clk);
        check("C_credits1", 32'(bus.o_credits_r), 32'd1);
        check("C_ack3_again", 32'(bus.o_req_ack), 32'b1000);
        check("C_busy_0111", 32'(bus.o_busy_r), 32'b0111);
        step();
        bus.i_req_vld = '0;
        @(negedge clk);
        check("C_credits_back0", 32'(bus.o_credits_r), 32'd0);

        // Two completions leave 2 credits; then issue ctxt 0 alongside completion of ctxt 1.
        step();
        cpl(1'b1, 0);
        step();
        cpl(1'b1, 2);
        step();
        cpl(1'b1, 1);
        bus.i_req_vld = 4'b0001;
        @(negedge clk);
        check("D_credits2", 32'(bus.o_credits_r), 32'd2);
        check("D_busy_1010", 32'(bus.o_busy_r), 32'b1010);
        check("D_ack0", 32'(bus.o_req_ack), 32'b0001);
        step();
        cpl(1'b0, 0);
        bus.i_req_vld = '0;
        @(negedge clk);
        check("D_credits_same", 32'(bus.o_credits_r), 32'd2);
        check("D_busy_1001", 32'(bus.o_busy_r), 32'b1001);

        // Completion for an idle context sets the sticky error only.
        step();
        cpl(1'b1, 2);
        step();
        cpl(1'b0, 0);
        @(negedge clk);
        check("E_err", 32'(bus.o_err_r), 32'd1);
        check("E_credits", 32'(bus.o_credits_r), 32'd2);
        check("E_busy", 32'(bus.o_busy_r), 32'b1001);
        step();
        @(negedge clk);
        check("E_err_sticky", 32'(bus.o_err_r), 32'd1);

        step();
        arst_n = 1'b0;
        step();
        step();
        arst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < int'(N); k++) begin
                if (last_ack[k]) begin
                    bus.i_req_vld[k] = 1'b0;
                end else if (!bus.i_req_vld[k] && ($urandom % 3) == 0) begin
                    bus.i_req_vld[k] = 1'b1;
                    bus.i_req_ptr[k*PW +: PW] = 8'($urandom);
                end else if (bus.i_req_vld[k] && ($urandom % 40) == 0) begin
                    bus.i_req_vld[k] = 1'b0;
                end
            end
            begin
                int c;
                c = int'($urandom_range(N - 1, 0));
                cpl(1'b0, c);
                if (($urandom % 3) == 0 && (m_busy[c] || ($urandom % 60) == 0)) cpl(1'b1, c);
            end
            arst_n = (($urandom % 400) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
